function_unit_seq: RTL and testbench

- Sequential function unit that sits directly downstream of the 16-entry register file.
- Consumes the A/B operand buses and the 4-bit FS select.
- Produces the registered result F and status flags; F is the value written back on the register file D input.
- Single-cycle ALU/shift ops complete in one cycle. Multiply, divide and remainder run as a 16-iteration shift-based sequence. The control unit uses the busy/done handshake to stall and to time the register-file write (RW).

---
 rtl/fu_pkg.sv | 31 +++
 rtl/seq_muldiv.sv | 83 ++++++++
 rtl/function_unit_seq.sv | 196 +++++++++++++++++++
 tb/tb_function_unit_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// rtl/fu_pkg.sv - opcode, state and helper definitions shared by the function unit
package fu_pkg;

    localparam logic [3:0] FS_MOV  = 4'b0000;
    localparam logic [3:0] FS_INC  = 4'b0001;
    localparam logic [3:0] FS_ADD  = 4'b0010;
    localparam logic [3:0] FS_SUB  = 4'b0011;
    localparam logic [3:0] FS_DEC  = 4'b0100;
    localparam logic [3:0] FS_AND  = 4'b0101;
    localparam logic [3:0] FS_OR   = 4'b0110;
    localparam logic [3:0] FS_XOR  = 4'b0111;
    localparam logic [3:0] FS_NOT  = 4'b1000;
    localparam logic [3:0] FS_MOVB = 4'b1001;
    localparam logic [3:0] FS_SHR  = 4'b1010;
    localparam logic [3:0] FS_MUL  = 4'b1011;
    localparam logic [3:0] FS_DIV  = 4'b1100;
    localparam logic [3:0] FS_REM  = 4'b1101;
    localparam logic [3:0] FS_SHL  = 4'b1110;
    localparam logic [3:0] FS_RSV  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] fs);
        return (fs == FS_MUL) || (fs == FS_DIV) || (fs == FS_REM);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative shift-add multiplier / restoring divider on one shared accumulator
module seq_muldiv
    import fu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               op_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quo_o,
    output logic [WIDTH-1:0]   rem_o
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               op_div_q, op_div_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] div_next;

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right with carry.
    // Divide:   acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        diff      = rem_shift - {1'b0, opnd_q};
        ge        = ~diff[WIDTH];
        div_next  = {(ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    end

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_div_d = op_div_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = {{WIDTH{1'b0}}, (op_div_i ? a_i : b_i)};
            opnd_d   = op_div_i ? b_i : a_i;
            op_div_d = op_div_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d = op_div_q ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            op_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_div_q <= op_div_d;
            cnt_q    <= cnt_d;
        end
    end

    // Results are taken from the post-step value so the parent can capture on the final step.
    assign last_o = (cnt_q == CW'(ITERS - 1));
    assign prod_o = acc_d;
    assign quo_o  = acc_d[WIDTH-1:0];
    assign rem_o  = acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/function_unit_seq.sv
// rtl/function_unit_seq.sv - sequential function unit with single-cycle ALU and iterative mul/div/rem
module function_unit_seq
    import fu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FS,
    output logic [WIDTH-1:0] F,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [3:0]       fs_q, fs_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;

    logic               md_load, md_step, md_last;
    logic [2*WIDTH-1:0] md_prod;
    logic [WIDTH-1:0]   md_quo, md_rem;

    seq_muldiv #(
        .WIDTH (WIDTH),
        .ITERS (ITERS)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .load_i   (md_load),
        .step_i   (md_step),
        .op_div_i (FS != FS_MUL),
        .a_i      (A),
        .b_i      (B),
        .last_o   (md_last),
        .prod_o   (md_prod),
        .quo_o    (md_quo),
        .rem_o    (md_rem)
    );

    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic             add_v;
    logic [WIDTH-1:0] alu_f;
    logic             alu_c, alu_v;

    // One adder serves inc/add/sub/dec by steering the second operand and carry-in.
    always_comb begin
        add_y   = '0;
        add_cin = 1'b0;
        case (FS)
            FS_INC:  add_cin = 1'b1;
            FS_ADD:  add_y   = B;
            FS_SUB:  begin add_y = ~B; add_cin = 1'b1; end
            FS_DEC:  add_y   = '1;
            default: ;
        endcase
        add_sum = {1'b0, A} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
        add_v   = (A[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
    end

    always_comb begin
        alu_f = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (FS)
            FS_MOV:  alu_f = A;
            FS_INC, FS_ADD, FS_SUB, FS_DEC: begin
                alu_f = add_sum[WIDTH-1:0];
                alu_c = add_sum[WIDTH];
                alu_v = add_v;
            end
            FS_AND:  alu_f = A & B;
            FS_OR:   alu_f = A | B;
            FS_XOR:  alu_f = A ^ B;
            FS_NOT:  alu_f = ~A;
            FS_MOVB: alu_f = B;
            FS_SHR:  begin alu_f = {1'b0, B[WIDTH-1:1]}; alu_c = B[0]; end
            FS_SHL:  begin alu_f = {B[WIDTH-2:0], 1'b0}; alu_c = B[WIDTH-1]; end
            FS_RSV:  alu_v = 1'b1;
            default: ;
        endcase
    end

    logic [WIDTH-1:0] md_f;
    logic             md_v;

    // Division by zero falls out of the restoring loop as all-ones / dividend; only V needs forcing.
    always_comb begin
        md_f = '0;
        md_v = 1'b0;
        case (fs_q)
            FS_MUL:  begin md_f = md_prod[WIDTH-1:0]; md_v = |md_prod[2*WIDTH-1:WIDTH]; end
            FS_DIV:  begin md_f = md_quo; md_v = bzero_q; end
            FS_REM:  begin md_f = md_rem; md_v = bzero_q; end
            default: ;
        endcase
    end

    logic             upd;
    logic [WIDTH-1:0] res_f;
    logic             res_c, res_v;

    always_comb begin
        state_d = state_q;
        fs_d    = fs_q;
        bzero_d = bzero_q;
        md_load = 1'b0;
        md_step = 1'b0;
        upd     = 1'b0;
        res_f   = alu_f;
        res_c   = alu_c;
        res_v   = alu_v;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_multicycle(FS)) begin
                        md_load = 1'b1;
                        fs_d    = FS;
                        bzero_d = (B == '0);
                        state_d = ST_ITER;
                    end else begin
                        upd     = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ITER: begin
                md_step = 1'b1;
                if (md_last) begin
                    upd     = 1'b1;
                    res_f   = md_f;
                    res_c   = 1'b0;
                    res_v   = md_v;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        f_d = f_q;
        c_d = c_q;
        v_d = v_q;
        n_d = n_q;
        z_d = z_q;
        if (upd) begin
            f_d = res_f;
            c_d = res_c;
            v_d = res_v;
            n_d = res_f[WIDTH-1];
            z_d = (res_f == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fs_q    <= FS_MOV;
            bzero_q <= 1'b0;
            f_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fs_q    <= fs_d;
            bzero_q <= bzero_d;
            f_q     <= f_d;
            c_q     <= c_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    assign F    = f_q;
    assign C    = c_q;
    assign V    = v_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_function_unit_seq.sv
// tb/tb_function_unit_seq.sv - self-checking bench for function_unit_seq
module tb_function_unit_seq;
    import fu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic [3:0]  FS = '0;
    logic [15:0] F;
    logic        C, V, N, Z, busy, done;

    int checks = 0;
    int errors = 0;

    function_unit_seq #(.WIDTH(16), .ITERS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .FS(FS),
        .F(F), .C(C), .V(V), .N(N), .Z(Z), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks required completion", checks);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference model straight from the opcode definitions, using wide integer arithmetic.
    task automatic model(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] f, output logic c, output logic v);
        int          si;
        logic [31:0] p;
        f = '0; c = 1'b0; v = 1'b0;
        case (fs)
            4'd0:  f = a;
            4'd1:  begin f = a + 16'd1; c = (a == 16'hFFFF); si = int'($signed(a)) + 1; v = (si > 32767); end
            4'd2:  begin p = 32'(a) + 32'(b); f = p[15:0]; c = (p > 32'd65535);
                         si = int'($signed(a)) + int'($signed(b)); v = (si > 32767) || (si < -32768); end
            4'd3:  begin f = a - b; c = (a >= b);
                         si = int'($signed(a)) - int'($signed(b)); v = (si > 32767) || (si < -32768); end
            4'd4:  begin f = a - 16'd1; c = (a != 0); si = int'($signed(a)) - 1; v = (si < -32768); end
            4'd5:  f = a & b;
            4'd6:  f = a | b;
            4'd7:  f = a ^ b;
            4'd8:  f = ~a;
            4'd9:  f = b;
            4'd10: begin f = b >> 1; c = b[0]; end
            4'd11: begin p = 32'(a) * 32'(b); f = p[15:0]; v = (p[31:16] != 0); end
            4'd12: if (b == 0) begin f = 16'hFFFF; v = 1'b1; end else f = a / b;
            4'd13: if (b == 0) begin f = a; v = 1'b1; end else f = a % b;
            4'd14: begin f = b << 1; c = b[15]; end
            default: v = 1'b1;
        endcase
    endtask

    task automatic run_op(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                          output int lat);
        @(negedge clk);
        FS = fs; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [3:0]  fs;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] f;
        logic        c;
        logic        v;
        int          lat;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int          lat;
        int          busy_cnt;
        int          done_at;
        int          dcount;
        logic [7:0]  dmask;
        logic [15:0] ef;
        logic        ec, ev;
        logic [3:0]  rfs;
        logic [15:0] ra, rb;

        tbl[0]  = '{FS_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1};
        tbl[1]  = '{FS_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1};
        tbl[2]  = '{FS_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1};
        tbl[3]  = '{FS_MUL,  16'h0100, 16'h0101, 16'h0100, 1'b0, 1'b1, 17};
        tbl[4]  = '{FS_DIV,  16'd1000, 16'd7,    16'd142,  1'b0, 1'b0, 17};
        tbl[5]  = '{FS_REM,  16'd1000, 16'd7,    16'd6,    1'b0, 1'b0, 17};
        tbl[6]  = '{FS_DIV,  16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 17};
        tbl[7]  = '{FS_REM,  16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b1, 17};
        tbl[8]  = '{FS_SHR,  16'h0005, 16'h0003, 16'h0001, 1'b1, 1'b0, 1};
        tbl[9]  = '{FS_RSV,  16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b1, 1};
        tbl[10] = '{FS_SHL,  16'h0000, 16'h8001, 16'h0002, 1'b1, 1'b0, 1};
        tbl[11] = '{FS_INC,  16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1};
        tbl[12] = '{FS_DEC,  16'h8000, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1};
        tbl[13] = '{FS_NOT,  16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0, 1};
        tbl[14] = '{FS_XOR,  16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1};

        repeat (2) @(negedge clk);
        chk("reset_F", 32'(F), 32'h0);
        chk("reset_CVNZ", 32'({C, V, N, Z}), 32'h0);
        chk("reset_busy_done", 32'({busy, done}), 32'h0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].fs, tbl[i].a, tbl[i].b, lat);
            chk($sformatf("tbl%0d_F", i), 32'(F), 32'(tbl[i].f));
            chk($sformatf("tbl%0d_CV", i), 32'({C, V}), 32'({tbl[i].c, tbl[i].v}));
            chk($sformatf("tbl%0d_NZ", i), 32'({N, Z}), 32'({tbl[i].f[15], tbl[i].f == 16'h0}));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
        end

        // MUL with start pulses during ITER: ignored, result held until DONE.
        run_op(FS_MOV, 16'hBEEF, 16'h0000, lat);
        @(negedge clk);
        FS = FS_MUL; A = 16'h0100; B = 16'h0101; start = 1'b1;
        busy_cnt = 0;
        done_at  = 0;
        for (int cyc = 1; cyc <= 30 && done_at == 0; cyc++) begin
            @(negedge clk);
            FS = FS_ADD; A = 16'h0001; B = 16'h0001;
            start = (cyc == 3) || (cyc == 10);
            if (busy) busy_cnt++;
            if (cyc == 8) chk("hold_F_mid_iter", 32'(F), 32'hBEEF);
            if (done) done_at = cyc;
        end
        start = 1'b0;
        chk("mul_done_cycle", 32'(done_at), 32'd17);
        chk("mul_busy_cycles", 32'(busy_cnt), 32'd17);
        chk("mul_F", 32'(F), 32'h0100);
        chk("mul_V", 32'(V), 32'h1);
        @(negedge clk);
        chk("mul_after_idle", 32'({busy, done}), 32'h0);

        // Reset mid-ITER of a MUL: outputs clear at once and the op never completes.
        run_op(FS_ADD, 16'h7FFF, 16'h0001, lat);
        @(negedge clk);
        FS = FS_MUL; A = 16'h1234; B = 16'h5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_F", 32'(F), 32'h0);
        chk("rst_mid_flags", 32'({C, V, N, Z}), 32'h0);
        chk("rst_mid_busy", 32'({busy, done}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("rst_no_done", 32'(dcount), 32'h0);

        // Back-to-back single-cycle ops: done on every other cycle.
        @(negedge clk);
        FS = FS_INC; A = 16'h0010; B = 16'h0000; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dmask[i] = done;
        end
        start = 1'b0;
        chk("b2b_done_pattern", 32'(dmask), 32'h55);
        chk("b2b_F", 32'(F), 32'h0011);

        for (int k = 0; k < 200; k++) begin
            rfs = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            model(rfs, ra, rb, ef, ec, ev);
            run_op(rfs, ra, rb, lat);
            chk($sformatf("rnd%0d_fs%0d_F", k, rfs), 32'(F), 32'(ef));
            chk($sformatf("rnd%0d_fs%0d_CV", k, rfs), 32'({C, V}), 32'({ec, ev}));
            chk($sformatf("rnd%0d_NZ", k), 32'({N, Z}), 32'({ef[15], ef == 16'h0}));
            chk($sformatf("rnd%0d_lat", k), 32'(lat),
                (rfs == 4'd11 || rfs == 4'd12 || rfs == 4'd13) ? 32'd17 : 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
